// File: rtl/kanade32_regdump_uart.sv
// kanade32_regdump_uart
//
// Debug consumer for the KANADE32 core's 1024-bit reg_debug bus. On request it
// snapshots all 32 GPRs and streams them as ASCII hex text over an 8N1 UART.
// Each register produces one line: 8 uppercase hex digits, MSB nibble first,
// followed by CR LF. Registers are sent in order 0..31.
//
// Optional build macro: KANADE32_REGDUMP_PREFIX_EN
//   When defined, every line is prefixed with "Rnn=", where nn is the
//   two-digit decimal register index (14 bytes per line instead of 10).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (minimum 2)
//
// Ports:
//   clk        CPU clock, all logic on rising edge
//   reset      asynchronous active-high reset
//   reg_debug  packed GPRs, register i at bits [32*i+31 : 32*i]
//   dump_req   level-sampled dump request, ignored while busy
//   busy       high while a dump is in progress
//   done       one-cycle pulse when a dump completes
//   uart_tx    serial output, idle high

module kanade32_regdump_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1023:0] reg_debug,
    input  logic          dump_req,
    output logic          busy,
    output logic          done,
    output logic          uart_tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef KANADE32_REGDUMP_PREFIX_EN
    localparam logic [3:0] CHAR_LAST = 4'd13;
`else
    localparam logic [3:0] CHAR_LAST = 4'd9;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q,  baud_d;
    logic [2:0]        bit_q,   bit_d;
    logic [3:0]        char_q,  char_d;
    logic [4:0]        reg_q,   reg_d;
    logic [1023:0]     snap_q,  snap_d;
    logic              done_q,  done_d;
    logic              tx_q,    tx_d;

    logic [31:0] cur_word;
    logic [2:0]  hex_pos;
    logic [3:0]  nibble;
    logic [7:0]  hex_ascii;
    logic [7:0]  cur_char;

    // Character currently being transmitted, derived from the snapshot and the
    // char/reg indices. The indices only move at the end of a stop bit, so this
    // is stable for the whole frame.
    always_comb begin
        cur_word = snap_q[{reg_q, 5'b00000} +: 32];
`ifdef KANADE32_REGDUMP_PREFIX_EN
        hex_pos = 3'(char_q - 4'd4);
`else
        hex_pos = char_q[2:0];
`endif
        // hex digit n of the line is nibble 7-n of the word; ~n == 7-n in 3 bits
        nibble    = cur_word[{~hex_pos, 2'b00} +: 4];
        hex_ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                     : (8'h37 + {4'h0, nibble});
        cur_char  = hex_ascii;
`ifdef KANADE32_REGDUMP_PREFIX_EN
        case (char_q)
            4'd0:    cur_char = 8'h52;
            4'd1:    cur_char = 8'h30 + 8'(reg_q / 5'd10);
            4'd2:    cur_char = 8'h30 + 8'(reg_q % 5'd10);
            4'd3:    cur_char = 8'h3D;
            4'd12:   cur_char = 8'h0D;
            4'd13:   cur_char = 8'h0A;
            default: cur_char = hex_ascii;
        endcase
`else
        case (char_q)
            4'd8:    cur_char = 8'h0D;
            4'd9:    cur_char = 8'h0A;
            default: cur_char = hex_ascii;
        endcase
`endif
    end

    // Frame sequencer. Bytes run back-to-back: the last cycle of a stop bit
    // advances straight into the next start bit unless the final LF was sent.
    // The tx bit is registered from the next-state values so uart_tx is a clean
    // flop output that changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        reg_d   = reg_q;
        snap_d  = snap_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dump_req) begin
                    state_d = S_START;
                    snap_d  = reg_debug;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    char_d  = 4'd0;
                    reg_d   = 5'd0;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if ((reg_q == 5'd31) && (char_q == CHAR_LAST)) begin
                        state_d = S_IDLE;
                        char_d  = 4'd0;
                        reg_d   = 5'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        if (char_q == CHAR_LAST) begin
                            char_d = 4'd0;
                            reg_d  = reg_q + 5'd1;
                        end else begin
                            char_d = char_q + 4'd1;
                        end
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_char[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            char_q  <= 4'd0;
            reg_q   <= 5'd0;
            snap_q  <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            reg_q   <= reg_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_kanade32_regdump_uart.sv
// tb_kanade32_regdump_uart
//
// Self-checking bench for kanade32_regdump_uart with CLKS_PER_BIT=4.
// Expected text is built from a per-register array and the line format rules;
// the serial stream is decoded by sampling uart_tx at bit centres.
// Honours KANADE32_REGDUMP_PREFIX_EN to select the line format.

module tb_kanade32_regdump_uart;

    localparam int CPB = 4;
`ifdef KANADE32_REGDUMP_PREFIX_EN
    localparam int LINE_BYTES = 14;
`else
    localparam int LINE_BYTES = 10;
`endif
    localparam int DUMP_BYTES = 32 * LINE_BYTES;
    localparam int DUMP_CYCLES = DUMP_BYTES * 10 * CPB;

    logic          clk;
    logic          reset;
    logic [1023:0] reg_debug;
    logic          dump_req;
    logic          busy;
    logic          done;
    logic          uart_tx;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_regs [32];
    logic [7:0]  rx [$];

    int   cyc = 0;
    int   busy_total = 0;
    int   done_total = 0;
    int   rise_cyc = 0;
    int   done_cyc = 0;
    logic prev_busy = 1'b0;

    kanade32_regdump_uart #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .reg_debug (reg_debug),
        .dump_req  (dump_req),
        .busy      (busy),
        .done      (done),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running bookkeeping of busy cycles and done pulses.
    always @(negedge clk) begin
        if (busy === 1'b1 && prev_busy !== 1'b1) rise_cyc = cyc;
        if (busy === 1'b1) busy_total = busy_total + 1;
        if (done === 1'b1) begin
            done_total = done_total + 1;
            done_cyc   = cyc;
        end
        prev_busy = busy;
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 32; i++) reg_debug[32*i +: 32] = model_regs[i];
    endtask

    task automatic randomizeRegs();
        for (int i = 0; i < 32; i++) model_regs[i] = $urandom;
    endtask

    // Expected byte k of the line for register r holding value v.
    function automatic logic [7:0] expChar(input logic [31:0] v, input int r, input int k);
        int kk;
        int nib;
        kk = k;
`ifdef KANADE32_REGDUMP_PREFIX_EN
        if (k == 0) return 8'h52;
        if (k == 1) return 8'(48 + r / 10);
        if (k == 2) return 8'(48 + r % 10);
        if (k == 3) return 8'h3D;
        kk = k - 4;
`endif
        if (kk == 8) return 8'h0D;
        if (kk == 9) return 8'h0A;
        nib = int'((v >> (28 - 4 * kk)) & 32'hF);
        return (nib < 10) ? 8'(48 + nib) : 8'(55 + nib);
    endfunction

    task automatic pulseReq();
        @(posedge clk); #1 dump_req = 1'b1;
        @(posedge clk); #1 dump_req = 1'b0;
    endtask

    // Decode n bytes. At byte poke_at, register 8 on the bus is changed and a
    // dump_req pulse is issued while the dump is running.
    task automatic recvBytes(input int n, input int poke_at);
        logic [7:0] d;
        bit found;
        rx.delete();
        for (int b = 0; b < n; b++) begin
            found = 1'b0;
            for (int t = 0; t < 20 * CPB; t++) begin
                @(negedge clk);
                if (uart_tx === 1'b0) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                checkOutput("start_bit_seen", 64'(found), 64'(1));
                return;
            end
            if (b == poke_at) begin
                reg_debug[32*8 +: 32] = 32'h12345678;
                dump_req = 1'b1;
            end
            repeat (CPB / 2) @(negedge clk);
            if (b == poke_at) dump_req = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                d[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            checkOutput("stop_bit", 64'(uart_tx), 64'(1));
            rx.push_back(d);
        end
    endtask

    task automatic checkDump(input string name);
        int r;
        int k;
        for (int i = 0; i < rx.size(); i++) begin
            r = i / LINE_BYTES;
            k = i % LINE_BYTES;
            checkOutput($sformatf("%s_byte%0d", name, i), 64'(rx[i]),
                        64'(expChar(model_regs[r], r, k)));
        end
    endtask

    task automatic waitDone();
        bit found;
        found = 1'b0;
        for (int t = 0; t < 10 * CPB; t++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", 64'(found), 64'(1));
        checkOutput("done_busy_low", 64'(busy), 64'(0));
        checkOutput("done_tx_idle", 64'(uart_tx), 64'(1));
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] first;
        int exp_bit;
        int d0;
        int b0;

        reset = 1'b1;
        dump_req = 1'b0;
        reg_debug = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_tx", 64'(uart_tx), 64'(1));
        reset = 1'b0;

        $display("[TB] single byte timing");
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        applyStimulus();
        first = expChar(32'h0, 0, 0);
        pulseReq();
        for (int c = 0; c < 11 * CPB; c++) begin
            @(negedge clk);
            if (c / CPB == 0)      exp_bit = 0;
            else if (c / CPB <= 8) exp_bit = int'(first[c / CPB - 1]);
            else if (c / CPB == 9) exp_bit = 1;
            else                   exp_bit = 0;
            checkOutput($sformatf("frame0_cycle%0d", c), 64'(uart_tx), 64'(exp_bit));
            if (c == 0) checkOutput("busy_after_accept", 64'(busy), 64'(1));
        end
        #2 reset = 1'b1;
        #1;
        checkOutput("reset1_tx", 64'(uart_tx), 64'(1));
        checkOutput("reset1_busy", 64'(busy), 64'(0));
        @(posedge clk); #1 reset = 1'b0;

        $display("[TB] content, snapshot isolation, ignored request, duration");
        for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        model_regs[8]  = 32'hDEADBEEF;
        model_regs[31] = 32'h004000A8;
        applyStimulus();
        d0 = done_total;
        b0 = busy_total;
        pulseReq();
        recvBytes(DUMP_BYTES, 50);
        checkOutput("dump1_count", 64'(rx.size()), 64'(DUMP_BYTES));
        checkDump("dump1");
        // request held across completion: accepted on the done cycle
        randomizeRegs();
        applyStimulus();
        dump_req = 1'b1;
        waitDone();
        checkOutput("dump1_span", 64'(done_cyc - rise_cyc), 64'(DUMP_CYCLES));
        checkOutput("dump1_busy_cycles", 64'(busy_total - b0), 64'(DUMP_CYCLES));
        checkOutput("dump1_done_pulses", 64'(done_total - d0), 64'(1));
        @(posedge clk); #1 dump_req = 1'b0;

        $display("[TB] back-to-back random dump");
        d0 = done_total;
        b0 = busy_total;
        recvBytes(DUMP_BYTES, -1);
        checkOutput("dump2_count", 64'(rx.size()), 64'(DUMP_BYTES));
        checkDump("dump2");
        waitDone();
        checkOutput("dump2_span", 64'(done_cyc - rise_cyc), 64'(DUMP_CYCLES));
        checkOutput("dump2_busy_cycles", 64'(busy_total - b0), 64'(DUMP_CYCLES));
        checkOutput("dump2_done_pulses", 64'(done_total - d0), 64'(1));
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 64'(busy), 64'(0));
        checkOutput("idle_done", 64'(done), 64'(0));
        checkOutput("idle_tx", 64'(uart_tx), 64'(1));

        $display("[TB] reset mid-dump");
        randomizeRegs();
        applyStimulus();
        pulseReq();
        recvBytes(17, -1);
        checkDump("pre_reset");
        repeat (CPB / 2 + CPB + 1) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset_tx", 64'(uart_tx), 64'(1));
        checkOutput("midreset_busy", 64'(busy), 64'(0));
        checkOutput("midreset_done", 64'(done), 64'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        randomizeRegs();
        applyStimulus();
        pulseReq();
        recvBytes(3 * LINE_BYTES, -1);
        checkOutput("restart_count", 64'(rx.size()), 64'(3 * LINE_BYTES));
        checkDump("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
